rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load/memory writeback).
- Accepts one request at a time over a valid/ready handshake and drives the register file write strobe, address and data.
- Holds the write until the register file returns write_finish, or until a timeout expires.
- Round-robin fairness when both requesters are valid; writes to r0 are acknowledged and discarded.

---
 rtl/rf_wb_arbiter_pkg.sv | 24 ++
 rtl/rf_wb_arbiter_rr.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM encoding,
// register-file geometry defaults and the timeout counter sizing helper.
package rf_wb_arbiter_pkg;

    // Register-file geometry defaults, shared with the register file itself.
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Architectural zero register: writes to it are accepted and dropped.
    localparam int REG_ZERO = 0;

    // Writeback FSM states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wb_state_e;

    // Width of the WRITE-cycle counter; one extra bit keeps the increment on
    // the final timeout cycle from wrapping.
    function automatic int cnt_width(input int ack_timeout);
        return $clog2(ack_timeout) + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Two-way round-robin selector: picks the single valid requester, or on a
// tie the requester that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Choose the winner and drive its one-hot grant.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (valid)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant_id = ~last_grant;
                if (last_grant) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the ALU writeback
// (requester 0) and the load writeback (requester 1). One request is accepted
// at a time; the write is held until the register file acknowledges it or the
// acknowledge timeout expires.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W      = RF_DATA_W,
    parameter int ADDR_W      = RF_ADDR_W,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    input  logic              rf_write_finish,
    output logic              busy,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_rd,
    output logic              err_timeout
);

    localparam int                CNT_W     = cnt_width(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] RD_ZERO   = ADDR_W'(REG_ZERO);

    wb_state_e         state_q,       state_d;
    logic              rf_write_q,    rf_write_d;
    logic [ADDR_W-1:0] rf_rd_q,       rf_rd_d;
    logic [DATA_W-1:0] rf_data_q,     rf_data_d;
    logic              pend_valid_q,  pend_valid_d;
    logic [ADDR_W-1:0] pend_rd_q,     pend_rd_d;
    logic              busy_q,        busy_d;
    logic              err_timeout_q, err_timeout_d;
    logic              last_grant_q,  last_grant_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;

    logic [1:0]        grant_s;
    logic              grant_id_s;
    logic [1:0]        ready_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_rd_s;
    logic [DATA_W-1:0] sel_data_s;

    rr_arbiter2 u_rr (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant_s),
        .grant_id   (grant_id_s)
    );

    // Ready goes only to the selected valid requester, only while idle and
    // never while reset is asserted; the grant is one-hot so at most one fires.
    always_comb begin
        ready_s = 2'b00;
        if (!rst && (state_q == ST_IDLE)) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
    end

    assign req0_ready = ready_s[0];
    assign req1_ready = ready_s[1];
    assign xfer_s     = |ready_s;

    // Route the winning requester's destination and payload.
    always_comb begin
        sel_rd_s   = req0_rd;
        sel_data_s = req0_data;
        if (grant_id_s) begin
            sel_rd_s   = req1_rd;
            sel_data_s = req1_data;
        end else begin
            sel_rd_s   = req0_rd;
            sel_data_s = req0_data;
        end
    end

    // Next-state logic: accept in IDLE, hold the write in WRITE until the
    // acknowledge arrives or the timeout window closes.
    always_comb begin
        state_d       = state_q;
        rf_write_d    = rf_write_q;
        rf_rd_d       = rf_rd_q;
        rf_data_d     = rf_data_q;
        pend_valid_d  = pend_valid_q;
        pend_rd_d     = pend_rd_q;
        busy_d        = busy_q;
        err_timeout_d = err_timeout_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    // Every transfer moves fairness, r0 discards included.
                    last_grant_d = grant_id_s;
                    if (sel_rd_s != RD_ZERO) begin
                        state_d      = ST_WRITE;
                        rf_write_d   = 1'b1;
                        rf_rd_d      = sel_rd_s;
                        rf_data_d    = sel_data_s;
                        pend_valid_d = 1'b1;
                        pend_rd_d    = sel_rd_s;
                        busy_d       = 1'b1;
                        cnt_d        = CNT_ZERO;
                    end else begin
                        // r0 write: acknowledged, nothing issued.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (rf_write_finish) begin
                    // Acknowledge wins even on the last timeout cycle.
                    state_d      = ST_IDLE;
                    rf_write_d   = 1'b0;
                    pend_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    rf_write_d    = 1'b0;
                    pend_valid_d  = 1'b0;
                    busy_d        = 1'b0;
                    err_timeout_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                rf_write_d   = 1'b0;
                pend_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rf_write_q    <= 1'b0;
            rf_rd_q       <= RD_ZERO;
            rf_data_q     <= DATA_W'(0);
            pend_valid_q  <= 1'b0;
            pend_rd_q     <= RD_ZERO;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            rf_write_q    <= rf_write_d;
            rf_rd_q       <= rf_rd_d;
            rf_data_q     <= rf_data_d;
            pend_valid_q  <= pend_valid_d;
            pend_rd_q     <= pend_rd_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rf_write    = rf_write_q;
    assign rf_rd       = rf_rd_q;
    assign rf_data     = rf_data_q;
    assign pend_valid  = pend_valid_q;
    assign pend_rd     = pend_rd_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_rf_wb_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int ACK = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_rd, req1_rd;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_write;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic          rf_write_finish;
    logic          busy, pend_valid, err_timeout;
    logic [AW-1:0] pend_rd;

    int checks   = 0;
    int failures = 0;

    // Reference model: a write is either in flight (with its age in cycles)
    // or not; fairness remembers who won the last transfer.
    bit            m_writing;
    int            m_age;
    logic [AW-1:0] m_rd, m_pend;
    logic [DW-1:0] m_data;
    bit            m_last;
    bit            m_err;
    bit            e_rdy0, e_rdy1;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ACK_TIMEOUT(ACK)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_rd         (req0_rd),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_rd         (req1_rd),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .rf_write        (rf_write),
        .rf_rd           (rf_rd),
        .rf_data         (rf_data),
        .rf_write_finish (rf_write_finish),
        .busy            (busy),
        .pend_valid      (pend_valid),
        .pend_rd         (pend_rd),
        .err_timeout     (err_timeout)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_writing = 1'b0;
        m_age     = 0;
        m_rd      = '0;
        m_pend    = '0;
        m_data    = '0;
        m_last    = 1'b1;
        m_err     = 1'b0;
    endtask

    // One clock: check mid-cycle, then advance the model across the edge.
    task automatic cycle();
        logic [AW-1:0] a_rd;
        logic [DW-1:0] a_data;
        #4;
        e_rdy0 = !rst && !m_writing && req0_valid && (!req1_valid || m_last);
        e_rdy1 = !rst && !m_writing && req1_valid && (!req0_valid || !m_last);
        check_val("req0_ready",  64'(req0_ready),  64'(e_rdy0));
        check_val("req1_ready",  64'(req1_ready),  64'(e_rdy1));
        check_val("rf_write",    64'(rf_write),    64'(m_writing));
        check_val("busy",        64'(busy),        64'(m_writing));
        check_val("pend_valid",  64'(pend_valid),  64'(m_writing));
        check_val("rf_rd",       64'(rf_rd),       64'(m_rd));
        check_val("rf_data",     64'(rf_data),     64'(m_data));
        check_val("pend_rd",     64'(pend_rd),     64'(m_pend));
        check_val("err_timeout", 64'(err_timeout), 64'(m_err));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_writing) begin
            m_age++;
            if (rf_write_finish) begin
                m_writing = 1'b0;
            end else if (m_age == ACK) begin
                m_writing = 1'b0;
                m_err     = 1'b1;
            end
        end else if (e_rdy0 || e_rdy1) begin
            m_last = e_rdy1;
            a_rd   = e_rdy1 ? req1_rd : req0_rd;
            a_data = e_rdy1 ? req1_data : req0_data;
            if (a_rd != '0) begin
                m_writing = 1'b1;
                m_age     = 0;
                m_rd      = a_rd;
                m_data    = a_data;
                m_pend    = a_rd;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid      = 1'b0;
        req1_valid      = 1'b0;
        rf_write_finish = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int            wr_cnt;
        logic [AW-1:0] rd_seq[$];
        bit            p0, p1;

        rst        = 1'b1;
        req0_rd    = '0;
        req1_rd    = '0;
        req0_data  = '0;
        req1_data  = '0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single ALU write acknowledged in its first WRITE cycle.
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hDEADBEEF;
        cycle();
        req0_valid = 1'b0;
        check_val("tp1_rf_rd", 64'(rf_rd), 64'd3);
        check_val("tp1_rf_data", 64'(rf_data), 64'hDEADBEEF);
        rf_write_finish = 1'b1;
        cycle();
        rf_write_finish = 1'b0;
        check_val("tp1_done", 64'({rf_write, busy}), 64'd0);
        cycle();

        // Both valid continuously, immediate acknowledge: strict alternation.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11111111;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22222222;
        rf_write_finish = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (rf_write) rd_seq.push_back(rf_rd);
        end
        check_val("rr_writes", 64'(rd_seq.size()), 64'd4);
        for (int i = 0; i < 4 && i < rd_seq.size(); i++) begin
            check_val("rr_rd_seq", 64'(rd_seq[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        idle_inputs();
        cycle();

        // r0 write discarded, queued ALU request taken the very next cycle.
        do_reset();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h00001234;
        cycle();
        check_val("r0_no_write", 64'(rf_write), 64'd0);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hCAFE0005;
        cycle();
        req0_valid = 1'b0;
        check_val("r0_next_rd", 64'(rf_rd), 64'd5);
        rf_write_finish = 1'b1;
        cycle();
        rf_write_finish = 1'b0;

        // Acknowledge never comes: write held exactly ACK cycles, sticky error.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0BADF00D;
        cycle();
        req0_valid = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < ACK + 4; i++) begin
            if (rf_write) wr_cnt++;
            cycle();
        end
        check_val("to_write_cycles", 64'(wr_cnt), 64'(ACK));
        check_val("to_err_sticky", 64'(err_timeout), 64'd1);

        // Reset in the second WRITE cycle, then a late acknowledge.
        do_reset();
        check_val("to_err_cleared", 64'(err_timeout), 64'd0);
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99999999;
        cycle();
        req0_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("mid_rst_idle", 64'({rf_write, pend_valid, busy, err_timeout}), 64'd0);
        rf_write_finish = 1'b1;
        cycle();
        rf_write_finish = 1'b0;
        cycle();

        // Acknowledge on the last timeout cycle: normal exit, no error.
        do_reset();
        req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'h12121212;
        cycle();
        req1_valid = 1'b0;
        for (int i = 0; i < ACK - 1; i++) cycle();
        rf_write_finish = 1'b1;
        cycle();
        rf_write_finish = 1'b0;
        check_val("edge_ack_exit", 64'(rf_write), 64'd0);
        check_val("edge_ack_no_err", 64'(err_timeout), 64'd0);
        cycle();

        // Randomized traffic; requesters hold their request until accepted.
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0        = 1'b1;
                req0_rd   = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
                req0_data = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1        = 1'b1;
                req1_rd   = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
                req1_data = $urandom;
            end
            req0_valid      = p0;
            req1_valid      = p1;
            rf_write_finish = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 299) == 0);
            cycle();
            if (e_rdy0) p0 = 1'b0;
            if (e_rdy1) p1 = 1'b0;
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
